// File: rtl/tdc_channel.sv
// tdc_channel: carry-chain TDC channel. The hit input feeds a NUM-tap CARRY4 delay line.
//   The taps pass through two capture ranks and are thermometer-decoded into one
//   event word (fine code, coarse timestamp, edge polarity).
// Latency: a hit captured by rank 1 at edge N gives out_valid=1 after edge N+2.
// Backpressure: valid/ready output. The word holds while stalled; an event that
//   arrives during a stall is dropped and sets the sticky overflow flag.
// Ports: clk/rst (sync, active-high); hit (async, chain CYINIT); enable and edge_mode
//   (00 off, 01 rising, 10 falling, 11 both); out_ready; clr_overflow;
//   out_valid/out_fine/out_coarse/out_rising (event word); overflow (sticky drop flag);
//   outTaps (rank-2 tap word, for debug).
module tdc_channel #(
  parameter  int NUM      = 64,
  parameter  int COARSE_W = 16,
  localparam int FW       = $clog2(NUM + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hit,
  input  logic                enable,
  input  logic [1:0]          edge_mode,
  input  logic                out_ready,
  input  logic                clr_overflow,
  output logic                out_valid,
  output logic [FW-1:0]       out_fine,
  output logic [COARSE_W-1:0] out_coarse,
  output logic                out_rising,
  output logic                overflow,
  output logic [NUM-1:0]      outTaps
);

  if ((NUM % 4) != 0 || NUM < 8) begin : g_bad_num
    $error("tdc_channel: NUM must be a multiple of 4 and at least 8");
  end

  // ---------------------------------------------------------------------------
  // Delay line and the two capture ranks
  // ---------------------------------------------------------------------------
`ifdef TDC_USE_UNISIM
  wire [NUM-1:0] chain_co;
  wire [NUM-1:0] r1_q;
  wire [NUM-1:0] r2_q;

  for (genvar s = 0; s < NUM / 4; s++) begin : g_chain
    if (s == 0) begin : g_first
      (* DONT_TOUCH = "TRUE" *)
      CARRY4 u_carry4 (
        .CO(chain_co[3:0]), .O(), .CI(1'b0), .CYINIT(hit),
        .DI(4'b0000), .S(4'b1111)
      );
    end else begin : g_next
      (* DONT_TOUCH = "TRUE" *)
      CARRY4 u_carry4 (
        .CO(chain_co[4*s+3:4*s]), .O(), .CI(chain_co[4*s-1]), .CYINIT(1'b0),
        .DI(4'b0000), .S(4'b1111)
      );
    end
  end

  for (genvar i = 0; i < NUM; i++) begin : g_rank
    (* DONT_TOUCH = "TRUE" *)
    FDRE #(.INIT(1'b0)) u_r1 (.Q(r1_q[i]), .C(clk), .CE(1'b1), .R(rst), .D(chain_co[i]));
    (* DONT_TOUCH = "TRUE" *)
    FDRE #(.INIT(1'b0)) u_r2 (.Q(r2_q[i]), .C(clk), .CE(1'b1), .R(rst), .D(r1_q[i]));
  end
`else
  // Behavioural equivalent of the CARRY4 cascade. The carry enters at CYINIT of
  // stage 0 (CI=0) and then ripples through the CI of each later stage. With S=1111
  // every bit propagates, so DI is never selected.
  localparam logic [3:0] S_BITS  = 4'b1111;
  localparam logic [3:0] DI_BITS = 4'b0000;

  logic [NUM-1:0] chain_co;
  (* DONT_TOUCH = "TRUE" *) logic [NUM-1:0] r1_q;
  (* DONT_TOUCH = "TRUE" *) logic [NUM-1:0] r2_q;

  always_comb begin : p_chain
    logic carry;
    chain_co = '0;
    carry    = hit;
    for (int i = 0; i < NUM; i++) begin
      carry       = S_BITS[2'(i)] ? carry : DI_BITS[2'(i)];
      chain_co[i] = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q <= '0;
      r2_q <= '0;
    end else begin
      r1_q <= chain_co;
      r2_q <= r1_q;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Coarse counter; the count travels down the pipe alongside the tap ranks
  // ---------------------------------------------------------------------------
  logic [COARSE_W-1:0] cnt_q, c1_q, c2_q;
  // Edge detection needs only tap 0 of the previous rank-2 word.
  logic                t2p0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      c1_q   <= '0;
      c2_q   <= '0;
      t2p0_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + COARSE_W'(1);
      c1_q   <= cnt_q;
      c2_q   <= c1_q;
      t2p0_q <= r2_q[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Event detection and fine decode
  // ---------------------------------------------------------------------------
  logic          rise_evt, fall_evt, evt;
  logic [FW-1:0] pop;
  logic [FW-1:0] fine_evt;

  assign rise_evt = enable & edge_mode[0] &  r2_q[0] & ~t2p0_q;
  assign fall_evt = enable & edge_mode[1] & ~r2_q[0] &  t2p0_q;
  assign evt      = rise_evt | fall_evt;

  // Popcount instead of a first-zero search, so bubbles in the thermometer
  // code do not disturb the result.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM; i++) begin
      pop = pop + FW'(r2_q[i]);
    end
  end

  assign fine_evt = rise_evt ? pop : (FW'(NUM) - pop);

  // ---------------------------------------------------------------------------
  // Output register with valid/ready and sticky overflow
  // ---------------------------------------------------------------------------
  logic                vld_q, vld_d;
  logic [FW-1:0]       fine_q, fine_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic                rise_q, rise_d;
  logic                ovf_q, ovf_d;
  logic                xfer, load, drop;

  assign xfer = vld_q & out_ready;
  assign load = evt & (~vld_q | out_ready);
  assign drop = evt & vld_q & ~out_ready;

  always_comb begin
    vld_d    = vld_q;
    fine_d   = fine_q;
    coarse_d = coarse_q;
    rise_d   = rise_q;
    ovf_d    = ovf_q;
    if (xfer) begin
      vld_d = 1'b0;
    end
    if (load) begin
      vld_d    = 1'b1;
      fine_d   = fine_evt;
      coarse_d = c2_q;
      rise_d   = rise_evt;
    end
    // A drop in the same cycle as a clear leaves the flag set.
    if (clr_overflow) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= 1'b0;
      fine_q   <= '0;
      coarse_q <= '0;
      rise_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      fine_q   <= fine_d;
      coarse_q <= coarse_d;
      rise_q   <= rise_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_fine   = fine_q;
  assign out_coarse = coarse_q;
  assign out_rising = rise_q;
  assign overflow   = ovf_q;
  assign outTaps    = r2_q;

endmodule

// File: tb/tb_tdc_channel.sv
// Testbench for tdc_channel. Taps are driven by forcing the carry-chain word that
// feeds rank 1. Expected values are hand-computed, and a simple cycle model
// tracks the coarse count.
module tb_tdc_channel;

  logic        clk = 1'b0;
  logic        rst, hit, enable, out_ready, clr_overflow;
  logic [1:0]  edge_mode;
  logic        out_valid, out_rising, overflow;
  logic [6:0]  out_fine;
  logic [15:0] out_coarse;
  logic [63:0] out_taps;

  logic        hit2, enable2, out_ready2, clr_overflow2;
  logic [1:0]  edge_mode2;
  logic        out_valid2, out_rising2, overflow2;
  logic [3:0]  out_fine2;
  logic [3:0]  out_coarse2;
  logic [7:0]  out_taps2;

  logic [63:0] fw;
  logic [7:0]  fw2;
  logic [15:0] cnt_m;
  logic [3:0]  cnt2_m;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  tdc_channel #(.NUM(64), .COARSE_W(16)) dut (
    .clk(clk), .rst(rst), .hit(hit), .enable(enable), .edge_mode(edge_mode),
    .out_ready(out_ready), .clr_overflow(clr_overflow), .out_valid(out_valid),
    .out_fine(out_fine), .out_coarse(out_coarse), .out_rising(out_rising),
    .overflow(overflow), .outTaps(out_taps)
  );

  tdc_channel #(.NUM(8), .COARSE_W(4)) dut2 (
    .clk(clk), .rst(rst), .hit(hit2), .enable(enable2), .edge_mode(edge_mode2),
    .out_ready(out_ready2), .clr_overflow(clr_overflow2), .out_valid(out_valid2),
    .out_fine(out_fine2), .out_coarse(out_coarse2), .out_rising(out_rising2),
    .overflow(overflow2), .outTaps(out_taps2)
  );

  // Coarse count model: cleared by rst, +1 per cycle, natural wrap.
  always @(posedge clk) begin
    if (rst) begin
      cnt_m  <= '0;
      cnt2_m <= '0;
    end else begin
      cnt_m  <= cnt_m + 16'd1;
      cnt2_m <= cnt2_m + 4'd1;
    end
  end

  typedef struct {
    logic [63:0] prev;
    logic [63:0] word;
    logic [1:0]  mode;
    logic        en;
    logic        exp_vld;
    logic [6:0]  exp_fine;
    logic        exp_rise;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_word(input logic [63:0] w);
    fw = w;
    force dut.chain_co = fw;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] cap;
    logic        found;

    vecs[0]  = '{64'h0,                  64'h7F_FFFF,             2'b01, 1'b1, 1'b1, 7'd23, 1'b1};
    vecs[1]  = '{64'h0,                  64'h2F_FFFF,             2'b11, 1'b1, 1'b1, 7'd21, 1'b1};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FF00_0000_0000, 2'b11, 1'b1, 1'b1, 7'd40, 1'b0};
    vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  2'b10, 1'b1, 1'b1, 7'd64, 1'b0};
    vecs[4]  = '{64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b1, 1'b1, 7'd64, 1'b1};
    vecs[5]  = '{64'h0,                  64'h1,                  2'b10, 1'b1, 1'b0, 7'd0,  1'b0};
    vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  2'b01, 1'b1, 1'b0, 7'd0,  1'b0};
    vecs[7]  = '{64'h0,                  64'h1,                  2'b00, 1'b1, 1'b0, 7'd0,  1'b0};
    vecs[8]  = '{64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 1'b0, 7'd0,  1'b0};
    vecs[9]  = '{64'h1,                  64'hF,                  2'b11, 1'b1, 1'b0, 7'd0,  1'b0};
    vecs[10] = '{64'h0,                  64'h8000_0000_0000_0001, 2'b01, 1'b1, 1'b1, 7'd2,  1'b1};
    vecs[11] = '{64'h1,                  64'hFFFF_FFFE,           2'b11, 1'b1, 1'b1, 7'd33, 1'b0};

    rst = 1'b1; hit = 1'b1; enable = 1'b1; edge_mode = 2'b01;
    out_ready = 1'b1; clr_overflow = 1'b0;
    hit2 = 1'b0; enable2 = 1'b1; edge_mode2 = 2'b01; out_ready2 = 1'b1; clr_overflow2 = 1'b0;
    fw = '0; fw2 = '0;
    force dut2.chain_co = fw2;

    // Reset state, with hit already high.
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_fine", out_fine, 0);
    chk("rst_coarse", out_coarse, 0);
    chk("rst_rising", out_rising, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_taps", out_taps, 0);
    chk("rst2_valid", out_valid2, 0);
    chk("rst2_fine", out_fine2, 0);
    chk("rst2_coarse", out_coarse2, 0);
    chk("rst2_rising", out_rising2, 0);
    chk("rst2_overflow", overflow2, 0);
    chk("rst2_taps", out_taps2, 0);

    // A hit that is already high gives one rising event after capture.
    rst = 1'b0;
    tick();
    chk("hit_early_valid", out_valid, 0);
    tick();
    chk("hit_taps", out_taps, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("hit_valid", out_valid, 1);
    chk("hit_fine", out_fine, 64);
    chk("hit_rising", out_rising, 1);
    chk("hit_coarse", out_coarse, 0);
    hit = 1'b0;
    repeat (5) tick();
    chk("hit_drain_valid", out_valid, 0);

    // Table-driven single-event vectors.
    set_word('0);
    for (int i = 0; i < 12; i++) begin
      enable    = vecs[i].en;
      edge_mode = vecs[i].mode;
      out_ready = 1'b1;
      set_word(vecs[i].prev);
      tick();
      set_word(vecs[i].word);
      cap = cnt_m;
      tick();
      set_word('0);
      tick(); tick();
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_vld);
      if (vecs[i].exp_vld) begin
        chk($sformatf("vec%0d_fine", i), out_fine, vecs[i].exp_fine);
        chk($sformatf("vec%0d_rising", i), out_rising, vecs[i].exp_rise);
        chk($sformatf("vec%0d_coarse", i), out_coarse, cap);
      end
      repeat (5) tick();
      chk($sformatf("vec%0d_drain", i), out_valid, 0);
    end
    enable = 1'b1;

    // Both mode, one pulse: rising then falling on consecutive cycles.
    edge_mode = 2'b11;
    set_word(64'hFFFF_FFFF_FFFF_FFFF);
    cap = cnt_m;
    tick();
    set_word('0);
    tick(); tick();
    chk("both_r_valid", out_valid, 1);
    chk("both_r_rising", out_rising, 1);
    chk("both_r_fine", out_fine, 64);
    chk("both_r_coarse", out_coarse, cap);
    tick();
    chk("both_f_valid", out_valid, 1);
    chk("both_f_rising", out_rising, 0);
    chk("both_f_fine", out_fine, 64);
    chk("both_f_coarse", out_coarse, cap + 16'd1);
    tick();
    chk("both_end_valid", out_valid, 0);
    repeat (3) tick();

    // Backpressure: hold, drop, overflow, clear, set-beats-clear.
    edge_mode = 2'b01;
    out_ready = 1'b0;
    set_word(64'hFFFF_FFFF_FFFF_FFFF);
    cap = cnt_m;
    tick();
    set_word('0);
    tick(); tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_fine", out_fine, 64);
    chk("bp_coarse", out_coarse, cap);
    chk("bp_ovf0", overflow, 0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_fine", out_fine, 64);
      chk("bp_hold_coarse", out_coarse, cap);
    end
    set_word(64'h7);
    tick();
    set_word('0);
    tick(); tick();
    chk("bp_drop_ovf", overflow, 1);
    chk("bp_drop_valid", out_valid, 1);
    chk("bp_drop_fine", out_fine, 64);
    chk("bp_drop_coarse", out_coarse, cap);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("bp_clr_ovf", overflow, 0);
    set_word(64'h3);
    tick();
    set_word('0);
    tick();
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("bp_setwins_ovf", overflow, 1);
    chk("bp_setwins_fine", out_fine, 64);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("bp_clr2_ovf", overflow, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_xfer_valid", out_valid, 0);
    repeat (3) tick();

    // Reset mid-operation: held word, overflow set, event sitting in rank 2.
    edge_mode = 2'b11;
    out_ready = 1'b0;
    set_word(64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    set_word('0);
    tick(); tick(); tick();
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_ovf", overflow, 1);
    tick(); tick();
    set_word(64'hFF);
    tick();
    set_word('0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_valid", out_valid, 0);
    chk("mid_fine", out_fine, 0);
    chk("mid_coarse", out_coarse, 0);
    chk("mid_rising", out_rising, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_taps", out_taps, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_after_valid", out_valid, 0);
    end

    // Coarse wrap on the small instance: events at count 15 and two cycles later.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (cnt2_m == 4'd15) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wrap_sync: count 15 not reached within budget");
    end
    fw2 = 8'h01;
    tick();
    fw2 = 8'h00;
    tick();
    fw2 = 8'h03;
    tick();
    chk("wrap1_valid", out_valid2, 1);
    chk("wrap1_fine", out_fine2, 1);
    chk("wrap1_coarse", out_coarse2, 15);
    chk("wrap1_rising", out_rising2, 1);
    fw2 = 8'h00;
    tick();
    chk("wrap_gap_valid", out_valid2, 0);
    tick();
    chk("wrap2_valid", out_valid2, 1);
    chk("wrap2_fine", out_fine2, 2);
    chk("wrap2_coarse", out_coarse2, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
